// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with programmable terminal count, synchronous
// clear/load, load validation and a one-cycle wrap pulse for cascading stages.

module bcd_digit (
  input  logic       up,
  input  logic       step,
  input  logic [3:0] d,
  output logic [3:0] nxt,
  output logic       carry
);
  always_comb begin
    nxt   = d;
    carry = 1'b0;
    if (step) begin
      if (up) begin
        if (d >= 4'd9) begin
          nxt   = 4'd0;
          carry = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nxt   = 4'd9;
          carry = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_counter_n #(
  parameter int                  DIGITS   = 3,
  parameter logic [4*DIGITS-1:0] TERMINAL = 12'h999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_err
);
  localparam int W = 4*DIGITS;

  function automatic logic nibs_ok(input logic [W-1:0] v);
    nibs_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) nibs_ok = 1'b0;
  endfunction

  localparam logic TERM_OK = nibs_ok(TERMINAL);

  logic [W-1:0]             count_q, count_d;
  logic                     wrap_q, wrap_d;
  logic                     load_err_q, load_err_d;
  logic [DIGITS:0]          carry;
  logic [DIGITS-1:0][3:0]   stepped;
  logic                     load_ok;

  // Digit 0 always steps; each digit's roll-over steps the next one. In down
  // mode the final borrow-out means every digit was zero, i.e. count == 0.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .up    (up_dn),
      .step  (carry[i]),
      .d     (count_q[4*i +: 4]),
      .nxt   (stepped[i]),
      .carry (carry[i+1])
    );
  end

  // With all nibbles valid BCD, a binary compare orders values correctly.
  assign load_ok = nibs_ok(load_val) && (load_val <= TERMINAL);

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (up_dn) begin
        if (count_q == TERMINAL) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = stepped;
        end
      end else begin
        if (carry[DIGITS]) begin
          count_d = TERMINAL;
          wrap_d  = 1'b1;
        end else begin
          count_d = stepped;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  always_ff @(posedge clk) begin
    cfg_chk: assert (TERM_OK) else $error("bcd_counter_n: TERMINAL has a nibble above 9");
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Drives three counter configurations (999 / 59 / 23) from shared controls and
// compares each against an integer-valued reference model every cycle.

module tb_bcd_counter_n;
  logic        clk = 1'b0;
  logic        reset, en, up_dn, clr, load;
  logic [11:0] lv0;
  logic [7:0]  lv1, lv2;
  logic [11:0] c0;
  logic [7:0]  c1, c2;
  logic        w0, w1, w2, e0, e1, e2;

  int checks = 0;
  int failures = 0;

  int m_cnt[3];
  bit m_wrap[3];
  bit m_err[3];
  int term[3] = '{999, 59, 23};
  int dig[3]  = '{3, 2, 2};

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(3), .TERMINAL(12'h999)) u0 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv0), .count(c0), .wrap(w0), .load_err(e0));
  bcd_counter_n #(.DIGITS(2), .TERMINAL(8'h59)) u1 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv1), .count(c1), .wrap(w1), .load_err(e1));
  bcd_counter_n #(.DIGITS(2), .TERMINAL(8'h23)) u2 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv2), .count(c2), .wrap(w2), .load_err(e2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] int2bcd(input int x);
    logic [11:0] r;
    int v;
    r = '0;
    v = x;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [11:0] v, input int nd);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      r += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic bit nibs_ok(input logic [11:0] v, input int nd);
    for (int i = 0; i < nd; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [11:0] lv_of(input int k);
    case (k)
      0:       return lv0;
      1:       return {4'h0, lv1};
      default: return {4'h0, lv2};
    endcase
  endfunction

  function automatic logic [11:0] cnt_of(input int k);
    case (k)
      0:       return c0;
      1:       return {4'h0, c1};
      default: return {4'h0, c2};
    endcase
  endfunction

  function automatic logic wrap_of(input int k);
    case (k)
      0:       return w0;
      1:       return w1;
      default: return w2;
    endcase
  endfunction

  function automatic logic err_of(input int k);
    case (k)
      0:       return e0;
      1:       return e1;
      default: return e2;
    endcase
  endfunction

  task automatic model_zero();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_wrap[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [11:0] v;
    for (int k = 0; k < 3; k++) begin
      m_wrap[k] = 1'b0;
      m_err[k]  = 1'b0;
      if (!reset) begin
        m_cnt[k] = 0;
      end else if (clr) begin
        m_cnt[k] = 0;
      end else if (load) begin
        v = lv_of(k);
        if (nibs_ok(v, dig[k]) && bcd2int(v, dig[k]) <= term[k]) m_cnt[k] = bcd2int(v, dig[k]);
        else m_err[k] = 1'b1;
      end else if (en) begin
        if (up_dn) begin
          if (m_cnt[k] == term[k]) begin m_cnt[k] = 0; m_wrap[k] = 1'b1; end
          else m_cnt[k] = m_cnt[k] + 1;
        end else begin
          if (m_cnt[k] == 0) begin m_cnt[k] = term[k]; m_wrap[k] = 1'b1; end
          else m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_cnt%0d", tag, k), 32'(cnt_of(k)), 32'(int2bcd(m_cnt[k])));
      chk($sformatf("%s_wrap%0d", tag, k), 32'(wrap_of(k)), 32'(m_wrap[k]));
      chk($sformatf("%s_err%0d", tag, k), 32'(err_of(k)), 32'(m_err[k]));
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    cmp_all(tag);
  endtask

  task automatic set_in(input bit c, input bit l, input bit e, input bit u);
    clr = c; load = l; en = e; up_dn = u;
  endtask

  task automatic do_load(input logic [11:0] a, input logic [7:0] b, input logic [7:0] d);
    lv0 = a; lv1 = b; lv2 = d;
    set_in(0, 1, 0, 1);
    cyc("load");
  endtask

  int nw, w_first, w_second;

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 1);
    lv0 = '0; lv1 = '0; lv2 = '0;
    model_zero();
    #12;
    cmp_all("rst");
    @(negedge clk) reset = 1'b1;

    // Up ripple and wrap
    do_load(12'h998, 8'h58, 8'h22);
    set_in(0, 0, 1, 1);
    cyc("up1"); chk("up_999", 32'(c0), 32'h999); chk("up_999_w", 32'(w0), 0);
    cyc("up2"); chk("up_000", 32'(c0), 32'h000); chk("up_000_w", 32'(w0), 1);
    cyc("up3"); chk("up_001", 32'(c0), 32'h001); chk("up_001_w", 32'(w0), 0);
    do_load(12'h099, 8'h09, 8'h19);
    set_in(0, 0, 1, 1);
    cyc("rip1"); chk("rip_100", 32'(c0), 32'h100);
    do_load(12'h009, 8'h19, 8'h09);
    set_in(0, 0, 1, 1);
    cyc("rip2"); chk("rip_010", 32'(c0), 32'h010);

    // Down and borrow
    do_load(12'h001, 8'h01, 8'h01);
    set_in(0, 0, 1, 0);
    cyc("dn1"); chk("dn_00", 32'(c1), 32'h00);
    cyc("dn2"); chk("dn_59", 32'(c1), 32'h59); chk("dn_59_w", 32'(w1), 1);
    cyc("dn3"); chk("dn_58", 32'(c1), 32'h58); chk("dn_58_w", 32'(w1), 0);
    do_load(12'h300, 8'h30, 8'h20);
    set_in(0, 0, 1, 0);
    cyc("dn4"); chk("dn_29", 32'(c1), 32'h29); chk("dn_299", 32'(c0), 32'h299);

    // Full period of the hours stage
    set_in(1, 0, 0, 1);
    cyc("pclr");
    set_in(0, 0, 1, 1);
    nw = 0; w_first = 0; w_second = 0;
    for (int i = 1; i <= 48; i++) begin
      cyc("per");
      if (w2) begin
        nw++;
        if (nw == 1) w_first = i;
        else if (nw == 2) w_second = i;
      end
    end
    chk("per_nwrap", 32'(nw), 2);
    chk("per_first", 32'(w_first), 24);
    chk("per_second", 32'(w_second), 48);
    chk("per_end", 32'(c2), 32'h00);

    // Load rejection
    do_load(12'h123, 8'h12, 8'h12);
    do_load(12'h9A0, 8'h60, 8'h24);
    chk("rej_err0", 32'(e0), 1); chk("rej_cnt0", 32'(c0), 32'h123);
    chk("rej_err1", 32'(e1), 1); chk("rej_cnt1", 32'(c1), 32'h12);
    chk("rej_err2", 32'(e2), 1);
    set_in(0, 0, 0, 1);
    cyc("rej_hold"); chk("rej_pulse", 32'(e0), 0);
    do_load(12'h045, 8'h45, 8'h15);
    chk("ld_45", 32'(c1), 32'h45); chk("ld_45_err", 32'(e1), 0);

    // Priority
    lv0 = 12'h777; lv1 = 8'h33; lv2 = 8'h11;
    set_in(1, 1, 1, 1);
    cyc("pri1"); chk("pri_clr", 32'(c0), 0);
    set_in(0, 1, 1, 1);
    cyc("pri2"); chk("pri_load", 32'(c0), 32'h777); chk("pri_load1", 32'(c1), 32'h33);

    // Async reset mid-count and mid-pulse
    do_load(12'h437, 8'h43, 8'h07);
    reset = 1'b0;
    #1;
    model_zero();
    cmp_all("arst");
    chk("arst_437", 32'(c0), 0);
    set_in(0, 0, 1, 1);
    cyc("arst_hold");
    @(negedge clk) reset = 1'b1;
    do_load(12'h999, 8'h59, 8'h23);
    set_in(0, 0, 1, 1);
    cyc("pw"); chk("pw_wrap", 32'(w0), 1);
    #2;
    reset = 1'b0;
    #1;
    model_zero();
    cmp_all("pw_rst");
    @(negedge clk) reset = 1'b1;
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc("idle");
    chk("idle_cnt", 32'(c0), 0);

    // Random
    for (int i = 0; i < 3000; i++) begin
      clr   = ($urandom_range(0, 31) == 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up_dn = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        lv0 = 12'($urandom); lv1 = 8'($urandom); lv2 = 8'($urandom);
      end else begin
        lv0 = int2bcd($urandom_range(0, 999));
        lv1 = 8'(int2bcd($urandom_range(0, 59)));
        lv2 = 8'(int2bcd($urandom_range(0, 23)));
      end
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
